// File: rtl/pingpong_pkg.sv
// Shared defaults and bank-state encoding for the ping-pong sample store.
package pingpong_pkg;

    localparam int unsigned PP_ADDR_W = 7;
    localparam int unsigned PP_DATA_W = 8;

    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_t;

endpackage

// File: rtl/pingpong_bank.sv
// One 2**ADDR_W x DATA_W bank: synchronous write, registered synchronous read.
module pingpong_bank
    import pingpong_pkg::*;
#(
    parameter int unsigned ADDR_W = PP_ADDR_W,
    parameter int unsigned DATA_W = PP_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= din;
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dout <= '0;
        else     dout <= mem[raddr];
    end

endmodule

// File: rtl/pingpong_ram.sv
// Ping-pong sample store: producer fills one bank while consumer reads the other.
// Optional PINGPONG_ERR_EN adds a sticky err_flag output for protocol misuse.
module pingpong_ram
    import pingpong_pkg::*;
#(
    parameter int unsigned ADDR_W = PP_ADDR_W,
    parameter int unsigned DATA_W = PP_DATA_W
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addra,
    input  logic              wea,
    input  logic [DATA_W-1:0] dina,
    input  logic              finisha,
    output logic              readya,
    input  logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] doutb,
    input  logic              finishb,
    output logic              readyb
`ifdef PINGPONG_ERR_EN
    ,
    output logic              err_flag
`endif
);

    bank_state_t       bank_st [2];
    bank_state_t       nxt_st  [2];
    logic              wsel, rsel, nxt_wsel, nxt_rsel;
    logic              rd_sel;
    logic              acc_a, acc_b;
    logic              we0, we1;
    logic [DATA_W-1:0] dout0, dout1;

    // An accepted finisha always targets a FREE bank and an accepted finishb a
    // FULL one, so both may update in the same cycle without conflict.
    always_comb begin
        acc_a    = finisha && readya;
        acc_b    = finishb && readyb;
        nxt_wsel = wsel;
        nxt_rsel = rsel;
        for (int unsigned i = 0; i < 2; i++) begin
            nxt_st[i] = bank_st[i];
            if (acc_a && (wsel == 1'(i))) nxt_st[i] = BANK_FULL;
            if (acc_b && (rsel == 1'(i))) nxt_st[i] = BANK_FREE;
        end
        if (acc_a) nxt_wsel = ~wsel;
        if (acc_b) nxt_rsel = ~rsel;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            bank_st[0] <= BANK_FREE;
            bank_st[1] <= BANK_FREE;
            wsel       <= 1'b0;
            rsel       <= 1'b0;
            rd_sel     <= 1'b0;
            readya     <= 1'b1;
            readyb     <= 1'b0;
        end else begin
            bank_st[0] <= nxt_st[0];
            bank_st[1] <= nxt_st[1];
            wsel       <= nxt_wsel;
            rsel       <= nxt_rsel;
            rd_sel     <= rsel;
            readya     <= (nxt_st[nxt_wsel] == BANK_FREE);
            readyb     <= (nxt_st[nxt_rsel] == BANK_FULL);
        end
    end

    assign we0 = wea && readya && (wsel == 1'b0);
    assign we1 = wea && readya && (wsel == 1'b1);

    pingpong_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
        .clk   (clk_in),
        .rst   (rst),
        .we    (we0),
        .waddr (addra),
        .din   (dina),
        .raddr (addrb),
        .dout  (dout0)
    );

    pingpong_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
        .clk   (clk_in),
        .rst   (rst),
        .we    (we1),
        .waddr (addra),
        .din   (dina),
        .raddr (addrb),
        .dout  (dout1)
    );

    // rd_sel is rsel as it was when the read was launched, so a bank swap
    // in the same cycle does not redirect data already in flight.
    assign doutb = rd_sel ? dout1 : dout0;

`ifdef PINGPONG_ERR_EN
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            err_flag <= 1'b0;
        else if (((wea || finisha) && !readya) || (finishb && !readyb))
            err_flag <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_pingpong_ram.sv
// Self-checking bench for pingpong_ram against a frame-count reference model.
module tb_pingpong_ram;

    logic       clk_in = 1'b0;
    logic       rst;
    logic [6:0] addra, addrb;
    logic       wea, finisha, finishb;
    logic [7:0] dina;
    logic       readya, readyb;
    logic [7:0] doutb;
`ifdef PINGPONG_ERR_EN
    logic       err_flag;
`endif

    pingpong_ram #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .addra   (addra),
        .wea     (wea),
        .dina    (dina),
        .finisha (finisha),
        .readya  (readya),
        .addrb   (addrb),
        .doutb   (doutb),
        .finishb (finishb),
        .readyb  (readyb)
`ifdef PINGPONG_ERR_EN
        ,
        .err_flag(err_flag)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Model: frames produced/consumed; bank = frame count mod 2.
    int         produced, consumed;
    logic [7:0] mem_m [2][128];
    logic [7:0] exp_dout;
    logic       exp_valid;
    logic       err_m;
    int         n_cmp, n_bad;

    function automatic logic m_ra();
        return (produced - consumed) < 2;
    endfunction

    function automatic logic m_rb();
        return produced > consumed;
    endfunction

    task automatic tick();
        logic ra, rb;
        ra = m_ra();
        rb = m_rb();
        exp_valid = rb;
        exp_dout  = mem_m[consumed % 2][addrb];
        if (wea && ra) mem_m[produced % 2][addra] = dina;
        if (((wea || finisha) && !ra) || (finishb && !rb)) err_m = 1'b1;
        if (finisha && ra) produced++;
        if (finishb && rb) consumed++;
        @(posedge clk_in);
        #1;
        wea = 1'b0; finisha = 1'b0; finishb = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #100;
        rst = 1'b0;
        produced = 0; consumed = 0; err_m = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (readya !== 1'b1) begin n_bad++; $display("FAIL reset_readya got=%b exp=1", readya); end
        n_cmp++; if (readyb !== 1'b0) begin n_bad++; $display("FAIL reset_readyb got=%b exp=0", readyb); end
        n_cmp++; if (doutb !== 8'd0) begin n_bad++; $display("FAIL reset_doutb got=%0d exp=0", doutb); end
`ifdef PINGPONG_ERR_EN
        n_cmp++; if (err_flag !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err_flag); end
`endif
    endtask

    task automatic test_fill_read();
        for (int a = 0; a < 128; a++) begin
            wea = 1'b1; addra = 7'(a); dina = 8'(a);
            tick();
        end
        n_cmp++; if (readyb !== 1'b0) begin n_bad++; $display("FAIL fill_readyb_pre got=%b exp=0", readyb); end
        finisha = 1'b1;
        tick();
        n_cmp++; if (readyb !== 1'b1) begin n_bad++; $display("FAIL fill_readyb got=%b exp=1", readyb); end
        n_cmp++; if (readya !== 1'b1) begin n_bad++; $display("FAIL fill_readya got=%b exp=1", readya); end
        addrb = 7'd5;
        tick();
        n_cmp++; if (doutb !== 8'd5) begin n_bad++; $display("FAIL fill_read5 got=%0d exp=5", doutb); end
    endtask

    task automatic test_stall();
        addrb = 7'd5;
        for (int a = 0; a < 128; a++) begin
            wea = 1'b1; addra = 7'(a); dina = 8'(a + 100);
            tick();
        end
        finisha = 1'b1;
        tick();
        n_cmp++; if (readya !== 1'b0) begin n_bad++; $display("FAIL stall_readya got=%b exp=0", readya); end
        n_cmp++; if (doutb !== 8'd5) begin n_bad++; $display("FAIL stall_read_b0 got=%0d exp=5", doutb); end
        finishb = 1'b1;
        tick();
        n_cmp++; if (readyb !== 1'b1) begin n_bad++; $display("FAIL stall_readyb got=%b exp=1", readyb); end
        n_cmp++; if (readya !== 1'b1) begin n_bad++; $display("FAIL stall_readya_back got=%b exp=1", readya); end
        tick();
        n_cmp++; if (doutb !== 8'd105) begin n_bad++; $display("FAIL stall_read_b1 got=%0d exp=105", doutb); end
    endtask

    task automatic test_misuse();
        finishb = 1'b1;
        tick();
        n_cmp++; if (readyb !== 1'b0) begin n_bad++; $display("FAIL misuse_drain got=%b exp=0", readyb); end
        finishb = 1'b1;
        tick();
        n_cmp++; if (readyb !== 1'b0 || readya !== 1'b1) begin
            n_bad++; $display("FAIL misuse_finishb got=%b%b exp=10", readya, readyb);
        end
        finisha = 1'b1; tick();
        finisha = 1'b1; tick();
        n_cmp++; if (readya !== 1'b0) begin n_bad++; $display("FAIL misuse_full got=%b exp=0", readya); end
        finisha = 1'b1; wea = 1'b1; addra = 7'd5; dina = 8'hEE; addrb = 7'd5;
        tick();
        n_cmp++; if (readya !== 1'b0 || readyb !== 1'b1) begin
            n_bad++; $display("FAIL misuse_finisha got=%b%b exp=01", readya, readyb);
        end
        tick();
        n_cmp++; if (doutb !== 8'd5) begin n_bad++; $display("FAIL misuse_nowrite got=%0d exp=5", doutb); end
`ifdef PINGPONG_ERR_EN
        n_cmp++; if (err_flag !== 1'b1) begin n_bad++; $display("FAIL misuse_err got=%b exp=1", err_flag); end
`endif
    endtask

    task automatic test_simultaneous();
        logic [6:0] a;
        logic [7:0] d;
        do_reset();
        finisha = 1'b1;
        tick();
        a = 7'($urandom_range(0, 127));
        d = 8'($urandom);
        wea = 1'b1; addra = a; dina = d;
        tick();
        finisha = 1'b1; finishb = 1'b1;
        tick();
        n_cmp++; if (readya !== 1'b1 || readyb !== 1'b1) begin
            n_bad++; $display("FAIL simul_ready got=%b%b exp=11", readya, readyb);
        end
        addrb = a;
        tick();
        n_cmp++; if (doutb !== d) begin n_bad++; $display("FAIL simul_read got=%0d exp=%0d", doutb, d); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            wea     = 1'($urandom_range(0, 1));
            addra   = 7'($urandom);
            dina    = 8'($urandom);
            addrb   = 7'($urandom);
            finisha = ($urandom_range(0, 9) == 0);
            finishb = ($urandom_range(0, 9) == 0);
            tick();
            n_cmp++; if (readya !== m_ra()) begin n_bad++; $display("FAIL rand_readya i=%0d got=%b exp=%b", i, readya, m_ra()); end
            n_cmp++; if (readyb !== m_rb()) begin n_bad++; $display("FAIL rand_readyb i=%0d got=%b exp=%b", i, readyb, m_rb()); end
            if (exp_valid) begin
                n_cmp++; if (doutb !== exp_dout) begin n_bad++; $display("FAIL rand_doutb i=%0d got=%0d exp=%0d", i, doutb, exp_dout); end
            end
`ifdef PINGPONG_ERR_EN
            n_cmp++; if (err_flag !== err_m) begin n_bad++; $display("FAIL rand_err i=%0d got=%b exp=%b", i, err_flag, err_m); end
`endif
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 4 && m_ra(); k++) begin
            finisha = 1'b1;
            tick();
        end
        n_cmp++; if (readya !== 1'b0 || readyb !== 1'b1) begin
            n_bad++; $display("FAIL areset_pre got=%b%b exp=01", readya, readyb);
        end
        @(negedge clk_in);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (readya !== 1'b1) begin n_bad++; $display("FAIL areset_readya got=%b exp=1", readya); end
        n_cmp++; if (readyb !== 1'b0) begin n_bad++; $display("FAIL areset_readyb got=%b exp=0", readyb); end
        n_cmp++; if (doutb !== 8'd0) begin n_bad++; $display("FAIL areset_doutb got=%0d exp=0", doutb); end
        #50;
        rst = 1'b0;
        produced = 0; consumed = 0; err_m = 1'b0;
        tick();
        n_cmp++; if (readya !== 1'b1 || readyb !== 1'b0) begin
            n_bad++; $display("FAIL areset_post got=%b%b exp=10", readya, readyb);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; wea = 1'b0; finisha = 1'b0; finishb = 1'b0;
        addra = '0; addrb = '0; dina = '0;
        produced = 0; consumed = 0; err_m = 1'b0;
        test_reset();
        test_fill_read();
        test_stall();
        test_misuse();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
